// File: rtl/signal_safety_monitor_pkg.sv
// Shared lamp codes, fault codes and monitor states for the signal safety monitor.
package signal_safety_monitor_pkg;

   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] AMBER = 3'b010;
   localparam logic [2:0] GREEN = 3'b001;
   localparam logic [2:0] DARK  = 3'b000;

   typedef enum logic [2:0] {
      FC_NONE        = 3'd0,
      FC_ILLEGAL     = 3'd1,
      FC_CONFLICT    = 3'd2,
      FC_TRANSITION  = 3'd3,
      FC_SHORT_AMBER = 3'd4
   } fault_code_t;

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

endpackage

// File: rtl/signal_safety_monitor_if.sv
// Controller-facing lamp codes and lamp-driver/fault outputs of the monitor.
interface signal_safety_monitor_if;
   import signal_safety_monitor_pkg::*;

   logic [2:0]  light_S1, light_S2, light_S3, light_S4;
   logic        fault_clr;
   logic [2:0]  lamp_S1, lamp_S2, lamp_S3, lamp_S4;
   logic        fault;
   fault_code_t fault_code;
   logic [3:0]  fault_src;

   modport master (
      output light_S1, light_S2, light_S3, light_S4, fault_clr,
      input  lamp_S1, lamp_S2, lamp_S3, lamp_S4, fault, fault_code, fault_src
   );

   modport slave (
      input  light_S1, light_S2, light_S3, light_S4, fault_clr,
      output lamp_S1, lamp_S2, lamp_S3, lamp_S4, fault, fault_code, fault_src
   );

endinterface

// File: rtl/signal_safety_monitor_approach_checker.sv
// Per-approach history and amber-run tracking; flags illegal codes,
// forbidden colour steps and amber intervals that end too early.
module approach_checker
   import signal_safety_monitor_pkg::*;
#(
   parameter int unsigned MIN_AMBER = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       accept,
   input  logic [2:0] code,
   output logic       illegal,
   output logic       bad_transition,
   output logic       short_amber,
   output logic       is_green
);

   localparam logic [3:0] MIN_A = 4'(MIN_AMBER);

   logic [2:0] hist;
   logic [2:0] amber_cnt;

   always_comb begin
      illegal        = !(code == RED || code == AMBER || code == GREEN);
      bad_transition = (hist == GREEN && code == RED)
                    || (hist == RED   && code == AMBER)
                    || (hist == AMBER && code == GREEN);
      short_amber    = (hist == AMBER) && (code == RED) && ({1'b0, amber_cnt} < MIN_A);
      is_green       = (code == GREEN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist      <= RED;
         amber_cnt <= '0;
      end else if (arm) begin
         hist      <= RED;
         amber_cnt <= '0;
      end else if (accept) begin
         hist <= code;
         if (code == AMBER)
            amber_cnt <= (amber_cnt == 3'd7) ? 3'd7 : amber_cnt + 3'd1;
         else
            amber_cnt <= '0;
      end
   end

endmodule

// File: rtl/signal_safety_monitor.sv
// Conflict monitor between the traffic-light controller and the lamp drivers;
// latches the first violation and flashes all-red until an operator clear.
module signal_safety_monitor
   import signal_safety_monitor_pkg::*;
#(
   parameter logic [5:0]  COMPAT     = 6'b000011,
   parameter int unsigned MIN_AMBER  = 3,
   parameter int unsigned ARM_CYCLES = 2,
   parameter int unsigned BLINK_HALF = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   signal_safety_monitor_if.slave   bus
);

   localparam logic [7:0] ARM_LAST   = 8'(ARM_CYCLES - 1);
   localparam logic [7:0] BLINK_LAST = 8'(2 * BLINK_HALF - 1);
   localparam logic [7:0] BH         = 8'(BLINK_HALF);

   state_t            state, state_nx;
   logic [7:0]        arm_cnt, arm_cnt_nx;
   logic [7:0]        blink_cnt, blink_cnt_nx;
   logic [3:0][2:0]   code, lamp_q, lamp_nx;
   logic              fault_q, fault_nx;
   fault_code_t       fc_q, fc_nx, fc_sel;
   logic [3:0]        src_q, src_nx, src_sel;
   logic [3:0]        ill, bad, shrt, grn, conf_src;
   logic [5:0]        conf;
   logic              fail, arm, accept;

   assign code   = {bus.light_S4, bus.light_S3, bus.light_S2, bus.light_S1};
   assign arm    = (state == ST_ARM);
   assign accept = (state == ST_RUN) && !fail;

   for (genvar g = 0; g < 4; g++) begin : g_chk
      approach_checker #(.MIN_AMBER(MIN_AMBER)) u_chk (
         .clk            (clk),
         .rst            (rst),
         .arm            (arm),
         .accept         (accept),
         .code           (code[g]),
         .illegal        (ill[g]),
         .bad_transition (bad[g]),
         .short_amber    (shrt[g]),
         .is_green       (grn[g])
      );
   end

   // Pair bits: 0=(1,2) 1=(1,3) 2=(1,4) 3=(2,3) 4=(2,4) 5=(3,4)
   assign conf[0] = grn[0] & grn[1] & ~COMPAT[0];
   assign conf[1] = grn[0] & grn[2] & ~COMPAT[1];
   assign conf[2] = grn[0] & grn[3] & ~COMPAT[2];
   assign conf[3] = grn[1] & grn[2] & ~COMPAT[3];
   assign conf[4] = grn[1] & grn[3] & ~COMPAT[4];
   assign conf[5] = grn[2] & grn[3] & ~COMPAT[5];
   assign conf_src = {conf[2] | conf[4] | conf[5],
                      conf[1] | conf[3] | conf[5],
                      conf[0] | conf[3] | conf[4],
                      conf[0] | conf[1] | conf[2]};

   always_comb begin
      fail    = 1'b1;
      fc_sel  = FC_NONE;
      src_sel = '0;
      if (|ill) begin
         fc_sel  = FC_ILLEGAL;
         src_sel = ill;
      end else if (|conf_src) begin
         fc_sel  = FC_CONFLICT;
         src_sel = conf_src;
      end else if (|bad) begin
         fc_sel  = FC_TRANSITION;
         src_sel = bad;
      end else if (|shrt) begin
         fc_sel  = FC_SHORT_AMBER;
         src_sel = shrt;
      end else begin
         fail = 1'b0;
      end
   end

   always_comb begin
      state_nx     = state;
      arm_cnt_nx   = arm_cnt;
      blink_cnt_nx = blink_cnt;
      lamp_nx      = lamp_q;
      fault_nx     = fault_q;
      fc_nx        = fc_q;
      src_nx       = src_q;
      unique case (state)
         ST_ARM: begin
            lamp_nx = {4{RED}};
            if (arm_cnt >= ARM_LAST) begin
               state_nx   = ST_RUN;
               arm_cnt_nx = '0;
            end else begin
               arm_cnt_nx = arm_cnt + 8'd1;
            end
         end
         ST_RUN: begin
            if (fail) begin
               state_nx     = ST_FAULT;
               fault_nx     = 1'b1;
               fc_nx        = fc_sel;
               src_nx       = src_sel;
               lamp_nx      = {4{RED}};
               blink_cnt_nx = '0;
            end else begin
               lamp_nx = code;
            end
         end
         ST_FAULT: begin
            if (bus.fault_clr) begin
               state_nx   = ST_ARM;
               arm_cnt_nx = '0;
               fault_nx   = 1'b0;
               fc_nx      = FC_NONE;
               src_nx     = '0;
               lamp_nx    = {4{RED}};
            end else begin
               blink_cnt_nx = (blink_cnt >= BLINK_LAST) ? 8'd0 : blink_cnt + 8'd1;
               lamp_nx      = (blink_cnt_nx < BH) ? {4{RED}} : {4{DARK}};
            end
         end
         default: state_nx = ST_ARM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_ARM;
         arm_cnt   <= '0;
         blink_cnt <= '0;
         lamp_q    <= {4{RED}};
         fault_q   <= 1'b0;
         fc_q      <= FC_NONE;
         src_q     <= '0;
      end else begin
         state     <= state_nx;
         arm_cnt   <= arm_cnt_nx;
         blink_cnt <= blink_cnt_nx;
         lamp_q    <= lamp_nx;
         fault_q   <= fault_nx;
         fc_q      <= fc_nx;
         src_q     <= src_nx;
      end
   end

   assign bus.lamp_S1    = lamp_q[0];
   assign bus.lamp_S2    = lamp_q[1];
   assign bus.lamp_S3    = lamp_q[2];
   assign bus.lamp_S4    = lamp_q[3];
   assign bus.fault      = fault_q;
   assign bus.fault_code = fc_q;
   assign bus.fault_src  = src_q;

endmodule

// File: tb/tb_signal_safety_monitor.sv
// Bench for signal_safety_monitor: directed fault scenarios plus a randomized
// controller walk, compared every cycle against a rule-level reference model.
module tb_signal_safety_monitor;
   import signal_safety_monitor_pkg::*;

   localparam logic [5:0]  COMPAT     = 6'b000011;
   localparam int unsigned MIN_AMBER  = 3;
   localparam int unsigned ARM_CYCLES = 2;
   localparam int unsigned BLINK_HALF = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   signal_safety_monitor_if bus();

   signal_safety_monitor #(
      .COMPAT     (COMPAT),
      .MIN_AMBER  (MIN_AMBER),
      .ARM_CYCLES (ARM_CYCLES),
      .BLINK_HALF (BLINK_HALF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode 0 = arming, 1 = running, 2 = faulted
   int         m_mode, m_arm_done, m_flash, m_code;
   logic [2:0] m_hist [4];
   int         m_amb  [4];
   logic [2:0] m_lamp [4];
   logic       m_fault;
   logic [3:0] m_src;
   logic [2:0] in_l   [4];
   logic       in_clr;

   function automatic int pair_bit(input int i, input int j);
      if (i == 0) return j - 1;
      if (i == 1) return j + 1;
      return 5;
   endfunction

   function automatic logic [2:0] forbidden_after(input logic [2:0] prev);
      case (prev)
         GREEN:   return RED;
         RED:     return AMBER;
         default: return GREEN;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0; m_arm_done = 0; m_flash = 0;
      m_fault = 1'b0; m_code = 0; m_src = '0;
      for (int i = 0; i < 4; i++) begin
         m_hist[i] = RED; m_amb[i] = 0; m_lamp[i] = RED;
      end
   endtask

   task automatic model_edge();
      logic [3:0] ill, conf, bad, shrt, sel;
      int code;
      case (m_mode)
         0: begin
            for (int i = 0; i < 4; i++) begin
               m_lamp[i] = RED; m_hist[i] = RED; m_amb[i] = 0;
            end
            m_arm_done++;
            if (m_arm_done >= int'(ARM_CYCLES)) begin
               m_mode = 1; m_arm_done = 0;
            end
         end
         1: begin
            ill = '0; conf = '0; bad = '0; shrt = '0;
            for (int i = 0; i < 4; i++) begin
               ill[i]  = ($countones(in_l[i]) != 1);
               bad[i]  = (in_l[i] == forbidden_after(m_hist[i]));
               shrt[i] = (m_hist[i] == AMBER) && (in_l[i] == RED) && (m_amb[i] < int'(MIN_AMBER));
               for (int j = i + 1; j < 4; j++)
                  if (in_l[i] == GREEN && in_l[j] == GREEN && COMPAT[pair_bit(i, j)] == 1'b0) begin
                     conf[i] = 1'b1; conf[j] = 1'b1;
                  end
            end
            code = 0; sel = '0;
            if (ill != 0)       begin code = 1; sel = ill;  end
            else if (conf != 0) begin code = 2; sel = conf; end
            else if (bad != 0)  begin code = 3; sel = bad;  end
            else if (shrt != 0) begin code = 4; sel = shrt; end
            if (code != 0) begin
               m_mode = 2; m_flash = 0; m_fault = 1'b1; m_code = code; m_src = sel;
               for (int i = 0; i < 4; i++) m_lamp[i] = RED;
            end else begin
               for (int i = 0; i < 4; i++) begin
                  m_lamp[i] = in_l[i];
                  m_amb[i]  = (in_l[i] == AMBER) ? ((m_amb[i] < 7) ? m_amb[i] + 1 : 7) : 0;
                  m_hist[i] = in_l[i];
               end
            end
         end
         default: begin
            if (in_clr) begin
               m_mode = 0; m_arm_done = 0;
               m_fault = 1'b0; m_code = 0; m_src = '0;
               for (int i = 0; i < 4; i++) m_lamp[i] = RED;
            end else begin
               m_flash++;
               for (int i = 0; i < 4; i++)
                  m_lamp[i] = (((m_flash / int'(BLINK_HALF)) % 2) == 1) ? DARK : RED;
            end
         end
      endcase
   endtask

   task automatic compare();
      check("lamps", 32'({bus.lamp_S1, bus.lamp_S2, bus.lamp_S3, bus.lamp_S4}),
            32'({m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3]}));
      check("fault", 32'(bus.fault), 32'(m_fault));
      check("fault_code", 32'(bus.fault_code), 32'(m_code));
      check("fault_src", 32'(bus.fault_src), 32'(m_src));
   endtask

   task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [2:0] d, input logic clr);
      in_l[0] = a; in_l[1] = b; in_l[2] = c; in_l[3] = d; in_clr = clr;
      bus.light_S1 = a; bus.light_S2 = b; bus.light_S3 = c; bus.light_S4 = d;
      bus.fault_clr = clr;
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic step_pat(input logic [11:0] p);
      step(p[11:9], p[8:6], p[5:3], p[2:0], 1'b0);
   endtask

   task automatic clear_and_arm();
      step(RED, RED, RED, RED, 1'b1);
      check("clr_fault_low", 32'(bus.fault), 32'd0);
      step(3'b111, GREEN, GREEN, GREEN, 1'b0);
      step(3'b000, GREEN, GREEN, GREEN, 1'b0);
   endtask

   // Controller cycle {S1,S2,S3,S4}; the S4 amber phase closes the loop legally
   localparam logic [11:0] PAT [6] = '{
      {GREEN, GREEN, RED,   RED  },
      {GREEN, AMBER, RED,   RED  },
      {GREEN, RED,   GREEN, RED  },
      {AMBER, RED,   AMBER, RED  },
      {RED,   RED,   RED,   GREEN},
      {RED,   RED,   RED,   AMBER}
   };
   localparam int DWELL [6] = '{8, 3, 6, 3, 7, 3};

   logic [2:0] w [4];
   logic [2:0] drv [4];
   logic       clr_r;

   initial begin
      rst = 1'b1;
      bus.light_S1 = RED; bus.light_S2 = RED; bus.light_S3 = RED; bus.light_S4 = RED;
      bus.fault_clr = 1'b0;
      model_reset();
      #3;
      compare();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Arming: inputs ignored, including on the ARM->RUN edge
      step(3'b111, GREEN, GREEN, GREEN, 1'b0);
      step(3'b011, GREEN, GREEN, GREEN, 1'b0);
      check("arm_no_fault", 32'(bus.fault), 32'd0);

      for (int rep = 0; rep < 3; rep++)
         for (int p = 0; p < 6; p++)
            for (int k = 0; k < DWELL[p] + int'($urandom_range(0, 2)); k++)
               step_pat(PAT[p]);
      check("cycle_no_fault", 32'(bus.fault), 32'd0);

      // S1 and S4 green together
      step(RED, RED, RED, RED, 1'b0);
      step(GREEN, RED, RED, GREEN, 1'b0);
      check("conflict_code", 32'(bus.fault_code), 32'd2);
      check("conflict_src", 32'(bus.fault_src), 32'b1001);
      for (int k = 0; k < 10; k++) step(GREEN, GREEN, GREEN, GREEN, 1'b0);
      clear_and_arm();

      // S2 amber held only two samples
      step(RED, RED, RED, RED, 1'b0);
      step(RED, GREEN, RED, RED, 1'b0);
      step(RED, AMBER, RED, RED, 1'b0);
      step(RED, AMBER, RED, RED, 1'b0);
      step(RED, RED, RED, RED, 1'b0);
      check("short_amber_code", 32'(bus.fault_code), 32'd4);
      check("short_amber_src", 32'(bus.fault_src), 32'b0010);
      clear_and_arm();

      // S3 green straight to red
      step(RED, RED, GREEN, RED, 1'b0);
      step(RED, RED, RED, RED, 1'b0);
      check("bad_trans_code", 32'(bus.fault_code), 32'd3);
      check("bad_trans_src", 32'(bus.fault_src), 32'b0100);
      clear_and_arm();

      // Illegal S1 code outranks an S2/S4 conflict in the same sample
      step(3'b011, GREEN, RED, GREEN, 1'b0);
      check("prio_code", 32'(bus.fault_code), 32'd1);
      check("prio_src", 32'(bus.fault_src), 32'b0001);
      clear_and_arm();

      // Randomized controller walk with occasional corrupt codes and clears
      for (int i = 0; i < 4; i++) w[i] = RED;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 4; i++) begin
            int r;
            r = int'($urandom_range(0, 63));
            if (r > 0 && r < 8)
               w[i] = (w[i] == GREEN) ? AMBER : (w[i] == AMBER) ? RED : GREEN;
            drv[i] = (r == 0) ? 3'($urandom) : w[i];
         end
         clr_r = (m_mode == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 20) == 0);
         step(drv[0], drv[1], drv[2], drv[3], clr_r);
      end

      // Asynchronous reset in the middle of a flash
      if (m_mode != 2) clear_and_arm();
      step(RED, RED, RED, RED, 1'b1);
      step(RED, RED, RED, RED, 1'b0);
      step(RED, RED, RED, RED, 1'b0);
      step(GREEN, RED, RED, GREEN, 1'b0);
      for (int k = 0; k < 5; k++) step(RED, RED, RED, RED, 1'b0);
      check("pre_rst_fault", 32'(bus.fault), 32'd1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_lamps", 32'({bus.lamp_S1, bus.lamp_S2, bus.lamp_S3, bus.lamp_S4}), 32'({4{RED}}));
      check("rst_fault", 32'(bus.fault), 32'd0);
      check("rst_code", 32'(bus.fault_code), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(RED, RED, RED, RED, 1'b0);
      step(RED, RED, RED, RED, 1'b0);
      for (int p = 0; p < 6; p++)
         for (int k = 0; k < DWELL[p]; k++) step_pat(PAT[p]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
